// File: rtl/rot_slice_scheduler.sv
// Measures rotor period from the hall index, slices each revolution into angular steps,
// and sequences one LOAD + two HUB75 half-transfers per slice. Optional watchdog: SLICE_WATCHDOG_EN.
module rot_slice_scheduler #(
  parameter int unsigned ROTATIONAL_RES = 1024,
  parameter int unsigned PER_W          = 24,
  parameter int unsigned MIN_PERIOD     = 4096,
  parameter int unsigned WDOG_CYCLES    = 65536,
  localparam int unsigned THETA_W       = $clog2(ROTATIONAL_RES)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               index_in,
  input  logic               hub75_ready,
  input  logic               hub75_last,
  output logic [THETA_W-1:0] theta,
  output logic               slice_start,
  output logic               half_sel,
  output logic               busy,
  output logic               locked,
  output logic [PER_W-1:0]   period,
  output logic [15:0]        overrun_count,
  output logic               wdog_err
);

  localparam logic [THETA_W-1:0] THETA_MAX = THETA_W'(ROTATIONAL_RES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HALF0, HALF1} state_t;

  state_t           state, state_nxt;
  logic             index_q, edge_det, valid_edge, cnt_sat, locked_nxt, tick, pending;
  logic [PER_W-1:0] cnt, cnt_shift, len_new, slice_len, timer;

  assign edge_det   = index_in & ~index_q;
  assign cnt_sat    = &cnt;
  assign valid_edge = edge_det & (cnt >= PER_W'(MIN_PERIOD)) & ~cnt_sat;
  assign cnt_shift  = cnt >> THETA_W;
  assign len_new    = (cnt_shift == '0) ? PER_W'(1) : cnt_shift;

  // A valid index edge is itself the slice-0 tick; the timer only ticks between edges.
  assign tick = valid_edge | (locked & ~edge_det & (timer == '0));

  always_comb begin
    locked_nxt = locked;
    if (valid_edge)              locked_nxt = 1'b1;
    else if (edge_det | cnt_sat) locked_nxt = 1'b0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      index_q   <= 1'b0;
      cnt       <= '0;
      period    <= '0;
      slice_len <= '0;
      locked    <= 1'b0;
      timer     <= '0;
      theta     <= '0;
    end else begin
      index_q <= index_in;
      if (edge_det)      cnt <= PER_W'(1);
      else if (!cnt_sat) cnt <= cnt + 1'b1;
      if (valid_edge) begin
        period    <= cnt;
        slice_len <= len_new;
      end
      locked <= locked_nxt;
      if (tick)                timer <= (valid_edge ? len_new : slice_len) - 1'b1;
      else if (timer != '0)    timer <= timer - 1'b1;
      // theta saturates at the last slice until the next index re-aligns it
      if (valid_edge || !locked_nxt)         theta <= '0;
      else if (tick && theta != THETA_MAX)   theta <= theta + 1'b1;
    end
  end

`ifdef SLICE_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wcnt;
  logic            wdog_fire;

  assign wdog_fire = ((state == HALF0) || (state == HALF1)) && (wcnt == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wcnt     <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state_nxt != state)                      wcnt <= '0;
      else if ((state == HALF0) || (state == HALF1)) wcnt <= wcnt + 1'b1;
      if (wdog_fire) wdog_err <= 1'b1;
    end
  end
`else
  assign wdog_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if ((tick | pending) & hub75_ready) state_nxt = LOAD;
      LOAD:    state_nxt = HALF0;
      HALF0:   if (hub75_last) state_nxt = HALF1;
      HALF1:   if (hub75_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef SLICE_WATCHDOG_EN
    if (wdog_fire) state_nxt = IDLE;
`endif
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      pending       <= 1'b0;
      overrun_count <= '0;
    end else begin
      state <= state_nxt;
      // a tick that cannot be queued (transfer running or one already pending) is dropped
      if (tick && (state != IDLE || pending) && overrun_count != 16'hFFFF)
        overrun_count <= overrun_count + 16'd1;
      if (!locked_nxt)                          pending <= 1'b0;
      else if (state == IDLE && (tick || pending)) pending <= ~hub75_ready;
    end
  end

  assign slice_start = (state == LOAD);
  assign half_sel    = (state == HALF1);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_rot_slice_scheduler.sv
// Randomized bench for rot_slice_scheduler against a time-arithmetic reference model.
`timescale 1ns/1ps
module tb_rot_slice_scheduler;
  localparam int RES = 16, PW = 16, MINP = 64, WD = 200, TW = 4;
  localparam int MAXC = 65535;

  logic clk_in = 1'b0, rst_in = 1'b1, index_in = 1'b0, hub75_ready = 1'b1, hub75_last = 1'b0;
  logic [TW-1:0] theta;
  logic slice_start, half_sel, busy, locked, wdog_err;
  logic [PW-1:0] period;
  logic [15:0] overrun_count;

  rot_slice_scheduler #(.ROTATIONAL_RES(RES), .PER_W(PW), .MIN_PERIOD(MINP), .WDOG_CYCLES(WD)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .index_in(index_in), .hub75_ready(hub75_ready),
    .hub75_last(hub75_last), .theta(theta), .slice_start(slice_start), .half_sel(half_sel),
    .busy(busy), .locked(locked), .period(period), .overrun_count(overrun_count), .wdog_err(wdog_err));

  always #5 clk_in = ~clk_in;

  int n_cmp = 0, n_bad = 0;
  // reference model: times are posedge indices since reset release
  int c, base, e_cyc, m_len, m_period, m_theta, m_st, m_ovr, m_wc;
  bit m_locked, m_pend, m_werr, m_idx_prev;
  bit idx, rdy, lst, rnd_last, rnd_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    c = 0; base = 1; e_cyc = 0; m_len = 1; m_period = 0; m_theta = 0; m_st = 0;
    m_ovr = 0; m_wc = 0; m_locked = 0; m_pend = 0; m_werr = 0; m_idx_prev = 0;
  endtask

  task automatic model_step();
    int cnt, prev;
    bit edg, valid, tick, req;
    c++;
    edg = idx && !m_idx_prev;
    m_idx_prev = idx;
    cnt = c - base;
    if (cnt > MAXC) cnt = MAXC;
    valid = edg && cnt >= MINP && cnt < MAXC;
    tick = valid || (m_locked && !edg && ((c - e_cyc) % m_len == 0));
    if (tick && (m_st != 0 || m_pend) && m_ovr < 65535) m_ovr++;
    prev = m_st;
    req = tick || m_pend;
    case (m_st)
      0: if (req && rdy) begin m_st = 1; m_pend = 0; end else if (req) m_pend = 1;
      1: m_st = 2;
      2: if (lst) m_st = 3;
      default: if (lst) m_st = 0;
    endcase
`ifdef SLICE_WATCHDOG_EN
    if (prev >= 2 && m_wc == WD - 1) begin m_st = 0; m_werr = 1; end
    if (m_st != prev) m_wc = 0; else if (m_st >= 2) m_wc++;
`endif
    if (valid) begin
      m_locked = 1; m_period = cnt; e_cyc = c;
      m_len = ((cnt >> TW) == 0) ? 1 : (cnt >> TW);
    end else if (edg || cnt == MAXC) m_locked = 0;
    if (edg) base = c;
    if (!m_locked) m_pend = 0;
    m_theta = m_locked ? (((c - e_cyc) / m_len > RES - 1) ? RES - 1 : (c - e_cyc) / m_len) : 0;
  endtask

  task automatic check_all();
    chk("theta", 32'(theta), 32'(m_theta));
    chk("slice_start", 32'(slice_start), 32'(m_st == 1));
    chk("half_sel", 32'(half_sel), 32'(m_st == 3));
    chk("busy", 32'(busy), 32'(m_st != 0));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("period", 32'(period), 32'(m_period));
    chk("overrun_count", 32'(overrun_count), 32'(m_ovr));
    chk("wdog_err", 32'(wdog_err), 32'(m_werr));
  endtask

  task automatic cyc();
    index_in = idx; hub75_ready = rdy; hub75_last = lst;
    @(posedge clk_in);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (rnd_last) lst = ($urandom % 4 == 0);
      if (rnd_rdy) rdy = ($urandom % 4 != 0);
      cyc();
    end
  endtask

  task automatic pulse();
    idx = 1; run(3); idx = 0;
  endtask

  task automatic wait_load();
    bit found;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      cyc();
      if (m_st == 1) found = 1;
    end
    if (!found) chk("wait_load_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int gap, n_ss;
    bit hit;
    model_reset();
    idx = 0; rdy = 1; lst = 0; rnd_last = 0; rnd_rdy = 0;
    repeat (3) @(posedge clk_in);
    #1 check_all();
    @(negedge clk_in) rst_in = 0;

    // lock onto a 1600-clock revolution
    rnd_last = 1;
    run(100); pulse(); run(1597); pulse();
    chk("lock_period", 32'(period), 32'd1600);
    chk("lock_flag", 32'(locked), 32'd1);
    run(1500);
    chk("theta_top", 32'(theta), 32'd15);
    run(200);
    chk("theta_hold", 32'(theta), 32'd15);

    // random revolutions with random ready / last
    rnd_rdy = 1;
    gap = 0;
    repeat (4) begin
      pulse();
      gap = $urandom_range(1000, 2000);
      run(gap);
    end

    // glitch: two edges 30 clocks apart
    rnd_rdy = 0; rdy = 1;
    pulse(); run(27); pulse();
    chk("glitch_unlock", 32'(locked), 32'd0);
    chk("glitch_period", 32'(period), 32'(gap + 3));
    n_ss = 0;
    for (int i = 0; i < 40; i++) begin cyc(); n_ss += int'(slice_start); end
    chk("glitch_no_load", 32'(n_ss), 32'd0);
    chk("glitch_theta", 32'(theta), 32'd0);

    // relock at 1600 (first edge here is too close to the glitch to count)
    pulse(); run(1597); pulse();
    chk("relock_period", 32'(period), 32'd1600);
    rnd_last = 0; lst = 1;
    run(20);

    // handshake and overrun
    lst = 0;
    wait_load();
    chk("hs_load", 32'(slice_start), 32'd1);
    chk("hs_half0", 32'(half_sel), 32'd0);
    gap = m_ovr;
    run(250);
    chk("overrun_two", 32'(overrun_count), 32'(gap + 2));
`ifdef SLICE_WATCHDOG_EN
    chk("wdog_idle", 32'(busy), 32'd0);
    chk("wdog_sticky", 32'(wdog_err), 32'd1);
`else
    chk("stall_busy", 32'(busy), 32'd1);
    chk("no_wdog", 32'(wdog_err), 32'd0);
`endif
    lst = 1; cyc(); lst = 0; cyc();
`ifndef SLICE_WATCHDOG_EN
    chk("hs_half1", 32'(half_sel), 32'd1);
`endif
    lst = 1; cyc(); lst = 0; cyc();
`ifndef SLICE_WATCHDOG_EN
    chk("hs_done", 32'(busy), 32'd0);
`endif

    // index edge coincident with timer expiry
    lst = 1; hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      if (m_locked && ((c + 1 - e_cyc) % m_len == 0) && (c + 1 - e_cyc) >= MINP) begin
        idx = 1; cyc(); idx = 0; hit = 1;
      end else cyc();
    end
    chk("collision_found", 32'(hit), 32'd1);
    chk("collision_theta", 32'(theta), 32'd0);
    n_ss = int'(slice_start);
    for (int i = 0; i < 3; i++) begin cyc(); n_ss += int'(slice_start); end
    chk("collision_one_load", 32'(n_ss), 32'd1);

    // asynchronous reset in the middle of HALF1
    lst = 0;
    wait_load();
    cyc(); lst = 1; cyc(); lst = 0;
    chk("pre_reset_half1", 32'(half_sel), 32'd1);
    #2 rst_in = 1;
    #1;
    chk("rst_theta", 32'(theta), 32'd0);
    chk("rst_slice_start", 32'(slice_start), 32'd0);
    chk("rst_half_sel", 32'(half_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_overrun", 32'(overrun_count), 32'd0);
    chk("rst_wdog", 32'(wdog_err), 32'd0);
    model_reset();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) rst_in = 0;
    rnd_last = 1;
    run(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
